ex_stage: RTL and testbench
===========================

# ex_stage

Parametrised execute stage for the pipelined MIPS datapath, sitting between the ID/EX and EX/MEM boundaries. It performs forwarding operand selection, the ALU operation, and an iterative multi-cycle multiply with a ready/stall handshake to the upstream stage. It owns the EX/MEM pipeline register, which carries registered results and control signals to the memory stage, and supports flush.

## Interface

Parameters:
- XLEN, 32: datapath width, must be ≥ 8 and a power of two.
- RA_W, 5: register-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID/EX holds a real instruction.
- id_rs_data, id_rt_data  in  XLEN  register-file operands.
- id_rs, id_rt  in  RA_W  source register numbers.
- id_imm  in  XLEN  sign-extended immediate.
- id_alu_src  in  1  1: B = id_imm; 0: B = forwarded rt.
- id_alu_op  in  4  operation code (see Operation).
- id_wr_addr  in  RA_W  destination register, already RegDst-selected.
- id_mem_to_reg, id_mem_read, id_mem_write, id_reg_write  in  1 each  control bits.
- memwb_reg_write  in  1  MEM/WB write enable.
- memwb_rd  in  RA_W  MEM/WB destination.
- memwb_data  in  XLEN  MEM/WB writeback value.
- flush  in  1  kill the instruction in EX.
- ex_ready  out  1  EX accepts id_* this cycle; combinational, equals state==IDLE.
- exm_valid  out  1  EX/MEM holds a real instruction.
- exm_result  out  XLEN  ALU or multiply result.
- exm_store_data  out  XLEN  forwarded rt value (store data).
- exm_wr_addr  out  RA_W  destination register.
- exm_zero, exm_overflow  out  1 each  result flags.
- exm_mem_to_reg, exm_mem_read, exm_mem_write, exm_reg_write  out  1 each  propagated control bits.

## Operation

- **Op codes:** 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MUL (low XLEN bits of the product), 12–15 produce result 0.
- **Shifts:** the operand is A; the shift amount is B[log2(XLEN)-1:0].
- **Flags:**
  - exm_zero = (result == 0).
  - exm_overflow is set only for signed overflow on ADD/SUB; it is 0 otherwise.
- **Forwarding** is applied independently to rs (giving A) and to rt (giving the forwarded rt value):
  - Register 0 is never forwarded.
  - First priority is EX/MEM: taken when exm_valid, exm_reg_write, !exm_mem_read and exm_wr_addr match.
  - Second priority is MEM/WB: taken when memwb_reg_write and memwb_rd match.
  - Otherwise the id_* register-file data is used.
  - Load-use hazards are resolved upstream.
- **FSM:**
  - **IDLE:** on each edge without flush, capture one instruction.
    - Non-MUL ops and bubbles go into EX/MEM; exm_valid = id_valid.
    - When invalid, all exm control bits are forced to 0.
    - A valid MUL latches A and B and the control bits, sets cnt = XLEN, moves to BUSY, and writes exm_valid = 0.
  - **BUSY:** performs one shift-add step per edge and decrements cnt. exm_valid = 0 while busy.
    - On the step where cnt goes 1→0, EX/MEM is loaded with the product and the latched control bits, exm_valid = 1, and the FSM returns to IDLE.
  - **Upstream hold:** upstream holds id_* stable while ex_ready = 0. id_* and memwb_* are ignored in BUSY.
- **flush:** has priority over everything.
  - On the edge it is sampled, exm_valid and all exm control bits go to 0.
  - Any multiply is aborted and the FSM returns to IDLE.
  - A simultaneous id_valid is discarded.

## Timing

- **Reset values:** all exm_* are 0, the FSM is in IDLE and ex_ready = 1, immediately on rst_n low without waiting for a clock edge. Reset during BUSY discards the multiply.
- **Non-MUL latency:** 1 cycle. id_* presented in cycle T appears on exm_* after edge T.
- **MUL latency:** XLEN cycles. Accepted at edge T, the result is valid after edge T+XLEN.
  - ex_ready = 0 from after edge T until edge T+XLEN.
  - The next instruction is accepted at edge T+XLEN+1 at the earliest.
- **Back-to-back non-MUL ops:** one per cycle, no bubbles.
- **Overflow on MUL:** none reported; the upper product bits are dropped.

## Structure

- **Package ex_pkg:**
  - ALU op-code localparams.
  - FSM state enum (IDLE, BUSY).
  - Forwarding-select enum (FWD_RF, FWD_EXM, FWD_WB).
- **Sub-module mul_iter:** a shift-add multiplier with start/abort/done, XLEN-parametrised, owning its counter. ex_stage instantiates it and owns the FSM, the ALU, the forwarding logic and the EX/MEM register.

## Test plan

- **Async reset:** drop rst_n mid-cycle during BUSY. Required: all exm_* = 0 and ex_ready = 1 with no clock edge.
- **Signed overflow on ADD:** ADD with A=0x7FFFFFFF and B=1. Required: after 1 cycle exm_result = 0x80000000, overflow = 1, zero = 0.
- **SUB and set-less-than:** SUB 5,5 gives zero = 1. SLT with 0xFFFFFFFF and 1 gives 1. SLTU with 0xFFFFFFFF and 1 gives 0.
- **Forwarding priority:** EX/MEM holds rd=5 with 0xA and MEM/WB holds rd=5 with 0xB. With id_rs=5, ADD with imm 0 gives 0xA. With id_rs=0 and id_rs_data 0, the result is 0 and no forwarding occurs.
- **Multiply:** MUL 0x00010003 × 0x00000005. Required:
  - ex_ready low for 32 cycles.
  - exm_valid = 0 throughout.
  - Then exm_result = 0x0005000F with exm_valid = 1.
- **Flush during multiply:** flush on the 10th BUSY cycle. Required: no result is produced, exm_valid stays 0, and ex_ready = 1 the next cycle.

Source files
------------

// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_pkg
//  Purpose  : Shared op codes, FSM states and forwarding selects for ex_stage.
//  Revision : 1.0
// ============================================================================
package ex_pkg;

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_nor  = 4'd5;
    localparam logic [3:0] c_op_slt  = 4'd6;
    localparam logic [3:0] c_op_sltu = 4'd7;
    localparam logic [3:0] c_op_sll  = 4'd8;
    localparam logic [3:0] c_op_srl  = 4'd9;
    localparam logic [3:0] c_op_sra  = 4'd10;
    localparam logic [3:0] c_op_mul  = 4'd11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage_if
//  Purpose  : ID/EX inputs, MEM/WB bypass, flush and EX/MEM outputs of ex_stage.
//  Revision : 1.0
// ============================================================================
interface ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [XLEN-1:0] id_rs_data;
    logic [XLEN-1:0] id_rt_data;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic [XLEN-1:0] id_imm;
    logic            id_alu_src;
    logic [3:0]      id_alu_op;
    logic [RA_W-1:0] id_wr_addr;
    logic            id_mem_to_reg;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_reg_write;
    logic            memwb_reg_write;
    logic [RA_W-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_data;
    logic            flush;
    logic            ex_ready;
    logic            exm_valid;
    logic [XLEN-1:0] exm_result;
    logic [XLEN-1:0] exm_store_data;
    logic [RA_W-1:0] exm_wr_addr;
    logic            exm_zero;
    logic            exm_overflow;
    logic            exm_mem_to_reg;
    logic            exm_mem_read;
    logic            exm_mem_write;
    logic            exm_reg_write;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_imm, id_alu_src,
               id_alu_op, id_wr_addr, id_mem_to_reg, id_mem_read, id_mem_write,
               id_reg_write, memwb_reg_write, memwb_rd, memwb_data, flush,
        input  ex_ready, exm_valid, exm_result, exm_store_data, exm_wr_addr, exm_zero,
               exm_overflow, exm_mem_to_reg, exm_mem_read, exm_mem_write, exm_reg_write
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_imm, id_alu_src,
               id_alu_op, id_wr_addr, id_mem_to_reg, id_mem_read, id_mem_write,
               id_reg_write, memwb_reg_write, memwb_rd, memwb_data, flush,
        output ex_ready, exm_valid, exm_result, exm_store_data, exm_wr_addr, exm_zero,
               exm_overflow, exm_mem_to_reg, exm_mem_read, exm_mem_write, exm_reg_write
    );
endinterface
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_iter
//  Purpose  : Radix-2 shift-add multiplier, one step per cycle, XLEN steps.
//  Revision : 1.0
// ============================================================================
module mul_iter #(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            i_start,
    input  wire logic            i_abort,
    input  wire logic [XLEN-1:0] i_a,
    input  wire logic [XLEN-1:0] i_b,
    output logic                 o_done,
    output logic [XLEN-1:0]      o_product
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [XLEN-1:0]  r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // done is flagged on the last step so the caller can capture the sum in the same edge
    assign o_done    = (r_cnt == CNT_W'(1));
    assign o_product = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_abort) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= CNT_W'(XLEN);
        end else if (r_cnt != '0) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : Execute stage: forwarding, ALU, iterative MUL and EX/MEM register.
//  Revision : 1.0
// ============================================================================
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input wire logic  clk,
    input wire logic  rst_n,
    ex_stage_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    state_t          r_state, w_state_next;
    fwd_sel_t        w_sel_rs, w_sel_rt;
    logic [XLEN-1:0] w_a, w_rt_fwd, w_b, w_sum, w_diff, w_alu_result;
    logic            w_ovf, w_is_mul, w_mul_start, w_mul_done, w_exm_fwd_en;
    logic [XLEN-1:0] w_product;
    logic [3:0]      w_id_ctrl;

    logic            r_exm_valid, r_exm_zero, r_exm_ovf;
    logic [XLEN-1:0] r_exm_result, r_exm_store;
    logic [RA_W-1:0] r_exm_wr_addr;
    logic [3:0]      r_exm_ctrl;
    logic [XLEN-1:0] r_pend_store;
    logic [RA_W-1:0] r_pend_wr_addr;
    logic [3:0]      r_pend_ctrl;

    function automatic fwd_sel_t fwd_pick(input logic [RA_W-1:0] src, exm_addr, wb_addr,
                                          input logic exm_en, wb_en);
        if (src == '0)                   return FWD_RF;
        if (exm_en && exm_addr == src)   return FWD_EXM;
        if (wb_en && wb_addr == src)     return FWD_WB;
        return FWD_RF;
    endfunction

    // A load's EX/MEM result is an address, never the loaded value
    assign w_exm_fwd_en = r_exm_valid & r_exm_ctrl[0] & ~r_exm_ctrl[2];
    assign w_sel_rs = fwd_pick(bus.id_rs, r_exm_wr_addr, bus.memwb_rd, w_exm_fwd_en, bus.memwb_reg_write);
    assign w_sel_rt = fwd_pick(bus.id_rt, r_exm_wr_addr, bus.memwb_rd, w_exm_fwd_en, bus.memwb_reg_write);

    always_comb begin
        w_a = bus.id_rs_data;
        case (w_sel_rs)
            FWD_EXM: w_a = r_exm_result;
            FWD_WB:  w_a = bus.memwb_data;
            default: w_a = bus.id_rs_data;
        endcase
        w_rt_fwd = bus.id_rt_data;
        case (w_sel_rt)
            FWD_EXM: w_rt_fwd = r_exm_result;
            FWD_WB:  w_rt_fwd = bus.memwb_data;
            default: w_rt_fwd = bus.id_rt_data;
        endcase
    end

    assign w_b    = bus.id_alu_src ? bus.id_imm : w_rt_fwd;
    assign w_sum  = w_a + w_b;
    assign w_diff = w_a - w_b;

    always_comb begin
        w_alu_result = '0;
        w_ovf        = 1'b0;
        case (bus.id_alu_op)
            c_op_add: begin
                w_alu_result = w_sum;
                w_ovf = (w_a[XLEN-1] == w_b[XLEN-1]) && (w_sum[XLEN-1] != w_a[XLEN-1]);
            end
            c_op_sub: begin
                w_alu_result = w_diff;
                w_ovf = (w_a[XLEN-1] != w_b[XLEN-1]) && (w_diff[XLEN-1] != w_a[XLEN-1]);
            end
            c_op_and:  w_alu_result = w_a & w_b;
            c_op_or:   w_alu_result = w_a | w_b;
            c_op_xor:  w_alu_result = w_a ^ w_b;
            c_op_nor:  w_alu_result = ~(w_a | w_b);
            c_op_slt:  w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            c_op_sltu: w_alu_result = {{(XLEN-1){1'b0}}, w_a < w_b};
            c_op_sll:  w_alu_result = w_a << w_b[SH_W-1:0];
            c_op_srl:  w_alu_result = w_a >> w_b[SH_W-1:0];
            c_op_sra:  w_alu_result = $unsigned($signed(w_a) >>> w_b[SH_W-1:0]);
            default:   w_alu_result = '0;
        endcase
    end

    assign w_is_mul  = bus.id_valid && (bus.id_alu_op == c_op_mul);
    assign w_id_ctrl = {bus.id_mem_to_reg, bus.id_mem_read, bus.id_mem_write, bus.id_reg_write};

    mul_iter #(.XLEN(XLEN)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_abort   (bus.flush),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.flush && w_is_mul) begin
                    w_state_next = BUSY;
                    w_mul_start  = 1'b1;
                end
            end
            BUSY: begin
                if (bus.flush || w_mul_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exm_valid    <= 1'b0;
            r_exm_zero     <= 1'b0;
            r_exm_ovf      <= 1'b0;
            r_exm_result   <= '0;
            r_exm_store    <= '0;
            r_exm_wr_addr  <= '0;
            r_exm_ctrl     <= '0;
            r_pend_store   <= '0;
            r_pend_wr_addr <= '0;
            r_pend_ctrl    <= '0;
        end else if (bus.flush) begin
            r_exm_valid <= 1'b0;
            r_exm_ctrl  <= '0;
        end else if (r_state == IDLE) begin
            if (w_is_mul) begin
                r_exm_valid    <= 1'b0;
                r_exm_ctrl     <= '0;
                r_pend_store   <= w_rt_fwd;
                r_pend_wr_addr <= bus.id_wr_addr;
                r_pend_ctrl    <= w_id_ctrl;
            end else begin
                r_exm_valid   <= bus.id_valid;
                r_exm_result  <= w_alu_result;
                r_exm_store   <= w_rt_fwd;
                r_exm_wr_addr <= bus.id_wr_addr;
                r_exm_zero    <= (w_alu_result == '0);
                r_exm_ovf     <= w_ovf;
                r_exm_ctrl    <= bus.id_valid ? w_id_ctrl : 4'b0000;
            end
        end else if (w_mul_done) begin
            r_exm_valid   <= 1'b1;
            r_exm_result  <= w_product;
            r_exm_store   <= r_pend_store;
            r_exm_wr_addr <= r_pend_wr_addr;
            r_exm_zero    <= (w_product == '0);
            r_exm_ovf     <= 1'b0;
            r_exm_ctrl    <= r_pend_ctrl;
        end
    end

    assign bus.ex_ready       = (r_state == IDLE);
    assign bus.exm_valid      = r_exm_valid;
    assign bus.exm_result     = r_exm_result;
    assign bus.exm_store_data = r_exm_store;
    assign bus.exm_wr_addr    = r_exm_wr_addr;
    assign bus.exm_zero       = r_exm_zero;
    assign bus.exm_overflow   = r_exm_ovf;
    assign bus.exm_mem_to_reg = r_exm_ctrl[3];
    assign bus.exm_mem_read   = r_exm_ctrl[2];
    assign bus.exm_mem_write  = r_exm_ctrl[1];
    assign bus.exm_reg_write  = r_exm_ctrl[0];
endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage
//  Purpose  : Directed vector and sequence bench for ex_stage.
//  Revision : 1.0
// ============================================================================
module tb_ex_stage;
    import ex_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();
    ex_stage #(.XLEN(32), .RA_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        src;
        logic [31:0] exp;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [3:0] op, input logic [4:0] rs, rt,
                          input logic [31:0] rsd, rtd, imm, input logic src,
                          input logic [4:0] wr, input logic [3:0] ctrl);
        bus.id_valid   = v;
        bus.id_alu_op  = op;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rs_data = rsd;
        bus.id_rt_data = rtd;
        bus.id_imm     = imm;
        bus.id_alu_src = src;
        bus.id_wr_addr = wr;
        {bus.id_mem_to_reg, bus.id_mem_read, bus.id_mem_write, bus.id_reg_write} = ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_low;
        int bad;
        logic [31:0] b_rt, b_imm;

        vt[0]  = '{c_op_add,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vt[1]  = '{c_op_sub,  32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vt[2]  = '{c_op_slt,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        vt[3]  = '{c_op_sltu, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[4]  = '{c_op_and,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'h00F0_00F0, 1'b0, 1'b0};
        vt[5]  = '{c_op_or,   32'h0000_00F0, 32'h0000_000F, 1'b1, 32'h0000_00FF, 1'b0, 1'b0};
        vt[6]  = '{c_op_xor,  32'hFFFF_0000, 32'hFF00_FF00, 1'b0, 32'h00FF_FF00, 1'b0, 1'b0};
        vt[7]  = '{c_op_nor,  32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vt[8]  = '{c_op_sll,  32'h0000_0001, 32'h0000_003F, 1'b1, 32'h8000_0000, 1'b0, 1'b0};
        vt[9]  = '{c_op_srl,  32'h8000_0000, 32'h0000_0004, 1'b1, 32'h0800_0000, 1'b0, 1'b0};
        vt[10] = '{c_op_sra,  32'h8000_0000, 32'h0000_0004, 1'b1, 32'hF800_0000, 1'b0, 1'b0};
        vt[11] = '{c_op_sub,  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vt[12] = '{4'd13,     32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[13] = '{c_op_add,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

        set_id(1'b0, c_op_add, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 4'b0000);
        bus.memwb_reg_write = 1'b0;
        bus.memwb_rd        = 5'd0;
        bus.memwb_data      = 32'h0;
        bus.flush           = 1'b0;

        #3;
        chk("reset_exm_valid", {31'b0, bus.exm_valid}, 32'h0);
        chk("reset_ex_ready",  {31'b0, bus.ex_ready},  32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back ALU vectors, one per cycle
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            b_rt  = vt[i].src ? 32'hDEAD_BEEF : vt[i].b;
            b_imm = vt[i].src ? vt[i].b : 32'hCAFE_F00D;
            set_id(1'b1, vt[i].op, 5'd0, 5'd0, vt[i].a, b_rt, b_imm, vt[i].src,
                   5'(i + 1), {i[0], 2'b00, 1'b1});
            tick();
            chk($sformatf("vec%0d_result", i), bus.exm_result, vt[i].exp);
            chk($sformatf("vec%0d_zero", i), {31'b0, bus.exm_zero}, {31'b0, vt[i].z});
            chk($sformatf("vec%0d_ovf", i), {31'b0, bus.exm_overflow}, {31'b0, vt[i].o});
            chk($sformatf("vec%0d_valid", i), {31'b0, bus.exm_valid}, 32'h1);
            chk($sformatf("vec%0d_wr_addr", i), {27'b0, bus.exm_wr_addr}, 32'(i + 1));
            chk($sformatf("vec%0d_mem_to_reg", i), {31'b0, bus.exm_mem_to_reg}, {31'b0, i[0]});
        end

        // forwarding priority and register-0 exclusion
        @(negedge clk);
        set_id(1'b1, c_op_add, 5'd0, 5'd0, 32'hA, 32'h0, 32'h0, 1'b1, 5'd5, 4'b0001);
        tick();
        chk("fwd_setup", bus.exm_result, 32'hA);
        @(negedge clk);
        set_id(1'b1, c_op_add, 5'd5, 5'd0, 32'h123, 32'h0, 32'h0, 1'b1, 5'd6, 4'b0001);
        bus.memwb_reg_write = 1'b1;
        bus.memwb_rd        = 5'd5;
        bus.memwb_data      = 32'hB;
        tick();
        chk("fwd_exm_priority", bus.exm_result, 32'hA);
        @(negedge clk);
        set_id(1'b1, c_op_add, 5'd5, 5'd6, 32'h123, 32'h456, 32'h0, 1'b1, 5'd0, 4'b0001);
        tick();
        chk("fwd_wb_rs", bus.exm_result, 32'hB);
        chk("fwd_exm_rt_store", bus.exm_store_data, 32'hA);
        @(negedge clk);
        set_id(1'b1, c_op_add, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 4'b0001);
        bus.memwb_rd = 5'd0;
        tick();
        chk("fwd_r0_result", bus.exm_result, 32'h0);
        chk("fwd_r0_zero", {31'b0, bus.exm_zero}, 32'h1);
        @(negedge clk);
        bus.memwb_reg_write = 1'b0;
        set_id(1'b1, c_op_add, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, 1'b1, 5'd7, 4'b0101);
        tick();
        @(negedge clk);
        set_id(1'b1, c_op_add, 5'd7, 5'd0, 32'h5, 32'h0, 32'h0, 1'b1, 5'd0, 4'b0001);
        tick();
        chk("fwd_no_load_bypass", bus.exm_result, 32'h5);

        // bubble must clear all control bits
        @(negedge clk);
        set_id(1'b0, c_op_add, 5'd0, 5'd0, 32'h1, 32'h0, 32'h0, 1'b1, 5'd3, 4'b1111);
        tick();
        chk("bubble_valid", {31'b0, bus.exm_valid}, 32'h0);
        chk("bubble_ctrl", {28'b0, bus.exm_mem_to_reg, bus.exm_mem_read,
                            bus.exm_mem_write, bus.exm_reg_write}, 32'h0);

        // multiply latency and result
        @(negedge clk);
        set_id(1'b1, c_op_mul, 5'd0, 5'd0, 32'h0001_0003, 32'h5, 32'h0, 1'b0, 5'd9, 4'b0001);
        tick();
        n_low = 0;
        bad   = 0;
        if (!bus.ex_ready) n_low++;
        if (bus.exm_valid) bad++;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.ex_ready) break;
            n_low++;
            if (bus.exm_valid) bad++;
        end
        chk("mul_ready_low_cycles", 32'(n_low), 32'd32);
        chk("mul_valid_while_busy", 32'(bad), 32'd0);
        chk("mul_result", bus.exm_result, 32'h0005_000F);
        chk("mul_valid", {31'b0, bus.exm_valid}, 32'h1);
        chk("mul_wr_addr", {27'b0, bus.exm_wr_addr}, 32'd9);
        chk("mul_reg_write", {31'b0, bus.exm_reg_write}, 32'h1);
        @(negedge clk);
        bus.id_valid = 1'b0;
        tick();
        chk("mul_after_valid", {31'b0, bus.exm_valid}, 32'h0);

        // flush on the 10th busy cycle
        @(negedge clk);
        set_id(1'b1, c_op_mul, 5'd0, 5'd0, 32'h0001_0003, 32'h5, 32'h0, 1'b0, 5'd9, 4'b0001);
        tick();
        chk("flush_mul_accepted", {31'b0, bus.ex_ready}, 32'h0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        tick();
        chk("flush_ready", {31'b0, bus.ex_ready}, 32'h1);
        chk("flush_valid", {31'b0, bus.exm_valid}, 32'h0);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.id_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.exm_valid || !bus.ex_ready) bad++;
        end
        chk("flush_no_result", 32'(bad), 32'd0);

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        set_id(1'b1, c_op_add, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 1'b1, 5'd4, 4'b1011);
        tick();
        @(negedge clk);
        set_id(1'b1, c_op_mul, 5'd0, 5'd0, 32'h3, 32'h3, 32'h0, 1'b0, 5'd9, 4'b0001);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_before", {31'b0, bus.ex_ready}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'b0, bus.ex_ready}, 32'h1);
        chk("rst_result", bus.exm_result, 32'h0);
        chk("rst_wr_addr", {27'b0, bus.exm_wr_addr}, 32'h0);
        chk("rst_ctrl", {27'b0, bus.exm_valid, bus.exm_mem_to_reg, bus.exm_mem_read,
                         bus.exm_mem_write, bus.exm_reg_write}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1'b1, c_op_add, 5'd0, 5'd0, 32'h10, 32'h0, 32'h20, 1'b1, 5'd2, 4'b0001);
        tick();
        chk("post_rst_add", bus.exm_result, 32'h30);
        chk("post_rst_valid", {31'b0, bus.exm_valid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
